pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL: stallD  in  1  load-use hazard from D-stage forwarding unit (load in E, dependent op in D).
REQ-004 SHALL: cannot_predictD  in  1  branch/jalr operand unresolvable in D.
REQ-005 SHALL: jump_codeD  in  2  D-stage control-flow class: 00 none, 01 branch, 10 jal, 11 jalr.
REQ-006 SHALL: mispredictE  in  1  E-stage resolved target differs from the predicted one.
REQ-007 SHALL: imem_ready  in  1  instruction-memory fetch data valid this cycle.
REQ-008 SHALL: dmem_busy  in  1  data-memory access in M not complete.
REQ-009 SHALL: enF  out  1  PC register update enable.
REQ-010 SHALL: enD  out  1  F/D register update enable.
REQ-011 SHALL: enE  out  1  D/E, E/M and M/W register update enable.
REQ-012 SHALL: flushD  out  1  load NOP bubble into F/D (valid only when enD=1).
REQ-013 SHALL: flushE  out  1  load NOP bubble into D/E (valid only when enE=1).
REQ-014 SHALL: pc_redirect  out  1  PC mux selects E-stage corrected target.
REQ-015 SHALL: state  out  3  FSM state: RUN=0, LDSTALL=1, PRED_WAIT=2, REDIRECT=3, MEM_WAIT=4.
REQ-016 SHALL: stall_cnt  out  32  count of cycles with enF=0.
REQ-017 SHALL: redirect_cnt  out  32  count of accepted redirects.

Function
REQ-018 SHALL: outputs enF..pc_redirect are combinational from current inputs and registered state; state and counters are registered.
REQ-019 SHALL: priority, highest first: dmem_busy, mispredictE, state==REDIRECT, stallD, cannot_predictD, imem_ready=0, normal.
REQ-020 SHALL: dmem_busy=1 -> enF=enD=enE=0, no flush, no redirect; next state MEM_WAIT; mispredictE ignored and honoured once dmem_busy drops.
REQ-021 SHALL: mispredictE=1 (dmem_busy=0) -> enF=enD=enE=1, flushD=flushE=1, pc_redirect=1; next state REDIRECT; redirect_cnt +1.
REQ-022 SHALL: in REDIRECT, stallD and cannot_predictD are ignored (D holds bubble); imem_ready=0 -> enF=0, enD=1, flushD=1, enE=1; next state RUN.
REQ-023 SHALL: stallD=1 -> enF=enD=0, enE=1, flushE=1; next state LDSTALL.
REQ-024 SHALL: cannot_predictD=1 with jump_codeD in {01,11} -> enF=enD=0, enE=1, flushE=1; next state PRED_WAIT; remains while asserted, no timeout.
REQ-025 SHALL: cannot_predictD=1 with jump_codeD in {00,10} is ignored.
REQ-026 SHALL: imem_ready=0 otherwise -> enF=0, enD=1, flushD=1, enE=1; next state RUN.
REQ-027 SHALL: normal -> enF=enD=enE=1, no flush, no redirect; next state RUN.
REQ-028 SHALL: LDSTALL lasts exactly as long as stallD; cannot_predictD asserted in the following cycle moves to PRED_WAIT without returning to RUN.
REQ-029 SHALL: stall_cnt and redirect_cnt saturate at 0xFFFFFFFF, no wrap.
REQ-030 SHALL: stall_cnt increments in any cycle where enF=0, including MEM_WAIT.

Reset
REQ-031 SHALL: rst_n=0 at a clock edge -> state=RUN, stall_cnt=0, redirect_cnt=0; during reset enF=enD=enE=1, flushD=flushE=1, pc_redirect=0.
REQ-032 SHALL: reset asserted mid-stall or mid-redirect aborts the sequence; first post-reset cycle behaves per RUN with current inputs.

Verification
REQ-033 SHALL: stallD=1 for 1 cycle from RUN -> enF=enD=0, flushE=1 that cycle; state=1 next; stall_cnt=1.
REQ-034 SHALL: mispredictE=1 with imem_ready=1 -> flushD=flushE=pc_redirect=1; next state=3; then RUN; redirect_cnt=1.
REQ-035 SHALL: dmem_busy=1 for 3 cycles plus mispredictE=1 throughout -> enables 0, pc_redirect=0 for 3 cycles; 4th cycle pc_redirect=1; stall_cnt=3.
REQ-036 SHALL: cannot_predictD=1, jump_codeD=01 for 2 cycles -> state=2 for 2 cycles, flushE=1 each; same with jump_codeD=10 -> no stall.
REQ-037 SHALL: stall_cnt preloaded to 0xFFFFFFFE by forcing, then 3 stall cycles -> stall_cnt=0xFFFFFFFF.
REQ-038 SHALL: rst_n=0 during PRED_WAIT -> next cycle state=0, counters 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Hazard / stall / flush controller for a five-stage pipeline.
//             Combinational enables and flushes from the current inputs and
//             the registered state, plus saturating stall and redirect
//             counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallD,
    input  logic        cannot_predictD,
    input  logic [1:0]  jump_codeD,
    input  logic        mispredictE,
    input  logic        imem_ready,
    input  logic        dmem_busy,
    output logic        enF,
    output logic        enD,
    output logic        enE,
    output logic        flushD,
    output logic        flushE,
    output logic        pc_redirect,
    output logic [2:0]  state,
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
);

    localparam logic [2:0] RUN       = 3'd0;
    localparam logic [2:0] LDSTALL   = 3'd1;
    localparam logic [2:0] PRED_WAIT = 3'd2;
    localparam logic [2:0] REDIRECT  = 3'd3;
    localparam logic [2:0] MEM_WAIT  = 3'd4;

    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    logic [2:0] next_state;
    logic       take_redirect;
    logic       branch_class;

    // Only branch (01) and jalr (11) need operands in D; bit 0 marks both.
    assign branch_class = jump_codeD[0];

    // Priority decode of pipeline enables, flushes and the next state.
    always_comb begin
        enF           = 1'b1;
        enD           = 1'b1;
        enE           = 1'b1;
        flushD        = 1'b0;
        flushE        = 1'b0;
        pc_redirect   = 1'b0;
        take_redirect = 1'b0;
        next_state    = RUN;
        if (!rst_n) begin
            // Keep the pipe moving but fill it with bubbles while in reset.
            flushD     = 1'b1;
            flushE     = 1'b1;
        end else if (dmem_busy) begin
            // Freeze everything; a pending mispredict is re-seen afterwards.
            enF        = 1'b0;
            enD        = 1'b0;
            enE        = 1'b0;
            next_state = MEM_WAIT;
        end else if (mispredictE) begin
            flushD        = 1'b1;
            flushE        = 1'b1;
            pc_redirect   = 1'b1;
            take_redirect = 1'b1;
            next_state    = REDIRECT;
        end else if (state == REDIRECT) begin
            // D holds the bubble just injected, so D-stage hazards are moot.
            if (!imem_ready) begin
                enF    = 1'b0;
                flushD = 1'b1;
            end
            next_state = RUN;
        end else if (stallD) begin
            enF        = 1'b0;
            enD        = 1'b0;
            flushE     = 1'b1;
            next_state = LDSTALL;
        end else if (cannot_predictD && branch_class) begin
            enF        = 1'b0;
            enD        = 1'b0;
            flushE     = 1'b1;
            next_state = PRED_WAIT;
        end else if (!imem_ready) begin
            enF        = 1'b0;
            flushD     = 1'b1;
            next_state = RUN;
        end
    end

    // State register and saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            stall_cnt    <= 32'd0;
            redirect_cnt <= 32'd0;
        end else begin
            state <= next_state;
            if (!enF && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (take_redirect && redirect_cnt != CNT_MAX) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire
